mem_timer_responder: RTL
========================

Name: mem_timer_responder

Overview:
- Memory-mapped machine-timer peripheral acting as a responder on the core's data-memory bus (mem_req / mem_we / mem_addr / mem_byteen / mem_wdata in; mem_rdata / mem_err out).
- Sits beside the data RAM, decoded from a fixed address window.
- Keeps a 64-bit prescaled time counter and a 64-bit compare register, and raises one interrupt line that feeds a bit of interrupt_vect.
- mem_rdata is zero whenever the block is not answering, so the top level can OR it with other responders.

Parameters:
- XLEN, 32, bus data/address width (fixed 32 in this design)
- BASE_ADDR, 32'h0004_0000, window base; must be 32-byte aligned
- PRESCALE_W, 16, width of the prescaler reload field and counter

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- mem_req  in  1  access strobe, valid for one cycle per access
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  XLEN  byte address
- mem_byteen  in  XLEN/8  byte enables for writes
- mem_wdata  in  XLEN  write data
- mem_rdata  out  XLEN  read data, valid when mem_rvalid = 1, otherwise 0
- mem_rvalid  out  1  read-data-valid pulse
- mem_err  out  1  access-error pulse
- timer_irq  out  1  level interrupt to interrupt_vect

Behaviour:
- Hit: mem_req and mem_addr[31:5] == BASE_ADDR[31:5]. mem_addr[1:0] is ignored; offset is mem_addr[4:2].
- Register map:
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 EN, bit1 IRQ_EN, bits[31:16] PRESC_RELOAD (low PRESCALE_W bits used), other bits read 0
  - 0x14 STATUS: bit0 PENDING, write-1-to-clear, other bits read 0
  - 0x18..0x1C unmapped
- Reset values: mtime = 0, mtimecmp = all ones, CTRL = 0, PENDING = 0, prescaler count = 0, mem_rdata = 0, mem_rvalid = 0, mem_err = 0, timer_irq = 0.
- Reads:
  - Latency 1 cycle: a hit read in cycle N gives mem_rvalid = 1 and mem_rdata = register value sampled at edge N in cycle N+1.
  - Back-to-back reads are allowed, one per cycle, with no stall.
- Writes:
  - Committed on the clock edge of the request cycle; only bytes with byteen = 1 change.
  - No mem_rvalid is returned for a write.
- Unmapped hit (offset 0x18 or 0x1C, read or write): mem_err = 1 for one cycle at N+1, mem_rdata = 0, mem_rvalid = 0, no state change.
- Non-hit cycles: all outputs 0 in the next cycle.
- Prescaler:
  - While EN = 1: if count == 0, raise tick, then count <= PRESC_RELOAD; else count <= count - 1.
  - Reload 0 gives a tick every cycle. Reload R gives a tick every R+1 cycles.
  - EN = 0 freezes count and mtime.
- mtime <= mtime + 1 on tick, 64-bit, wraps from all ones to 0.
- A bus write to MTIME_LO or MTIME_HI takes priority over the tick in that cycle (tick dropped). The written half takes the new bytes; the other half holds.
- PENDING:
  - Set in every cycle where mtime >= mtimecmp (unsigned 64-bit compare on registered values).
  - A W1C write clears it, but the set condition wins if both occur in the same cycle.
- timer_irq = PENDING & IRQ_EN, registered (one cycle after PENDING).
- Reset asserted mid-access: all state returns to reset values immediately; a pending read response is discarded (no mem_rvalid after reset).

Optional Feature:
- Macro TIMER_SHADOW_EN.
- Defined:
  - A read of MTIME_LO also latches mtime[63:32] into a shadow register.
  - Reads of MTIME_HI return the shadow, giving coherent 64-bit reads across a low-word carry.
  - Shadow resets to 0.
- Undefined: MTIME_HI reads return live mtime[63:32]; no shadow register exists.

Test Plan:
- Reset, then read each of offsets 0x00..0x14 -> rdata 0, 0, FFFFFFFF, FFFFFFFF, 0, 0; each rvalid exactly 1 cycle after its req; timer_irq = 0.
- Write CTRL = 0x0000_0001, MTIMECMP_HI = 0, MTIMECMP_LO = 10 -> mtime increments every cycle; PENDING set the cycle mtime reaches 10; timer_irq stays 0 until CTRL = 0x3, then asserts one cycle later.
- CTRL = 0x0003_0001 (reload 3) -> mtime advances once per 4 cycles; read MTIME_LO after 40 cycles returns 10 ±1 according to sampling edge.
- With mtime >= mtimecmp, write STATUS = 1 -> PENDING remains 1. Then set MTIMECMP_HI = FFFFFFFF and write STATUS = 1 -> PENDING 0, timer_irq drops the cycle after.
- Write MTIMECMP_LO = 0xAABBCCDD with byteen = 4'b0101 onto reset value -> reads FFBBFFDD. Read offset 0x18 -> mem_err pulse, rvalid 0, rdata 0.
- Preset mtime = 0x0000_0000_FFFF_FFFF, EN, reload 0; read LO then HI -> without TIMER_SHADOW_EN HI = 1 after carry; with TIMER_SHADOW_EN HI = 0 (shadowed).

Source files
------------

// File: rtl/mem_timer_responder.sv
// mem_timer_responder
//   Machine-timer peripheral answering on the core's data-memory bus.
//   It holds a 64-bit prescaled time counter (mtime), a 64-bit compare
//   register (mtimecmp), a CTRL/STATUS pair and one level interrupt.
//   Register window (32 bytes at BASE_ADDR, word offset mem_addr[4:2]):
//     0x00 MTIME_LO   0x04 MTIME_HI   0x08 MTIMECMP_LO   0x0C MTIMECMP_HI
//     0x10 CTRL  {PRESC_RELOAD[31:16], IRQ_EN[1], EN[0]}
//     0x14 STATUS {PENDING[0]} write-1-to-clear
//     0x18/0x1C unmapped -> mem_err pulse
//   Build option: define TIMER_SHADOW_EN so that a MTIME_LO read snapshots
//   mtime[63:32] and MTIME_HI reads return that snapshot.
// Ports:
//   clk, rst        core clock, asynchronous active-high reset
//   mem_req/we      access strobe (one cycle per access), write select
//   mem_addr        byte address
//   mem_byteen      write byte enables
//   mem_wdata       write data
//   mem_rdata       read data, registered, zero unless mem_rvalid
//   mem_rvalid      read response pulse, one cycle after the request
//   mem_err         unmapped-offset pulse, one cycle after the request
//   timer_irq       registered PENDING & IRQ_EN
module mem_timer_responder #(
   parameter int          XLEN       = 32,
   parameter logic [31:0] BASE_ADDR  = 32'h0004_0000,
   parameter int          PRESCALE_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [XLEN-1:0]   mem_addr,
   input  logic [XLEN/8-1:0] mem_byteen,
   input  logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN-1:0]   mem_rdata,
   output logic              mem_rvalid,
   output logic              mem_err,
   output logic              timer_irq
);

   // Byte-enable merge of a write onto an existing 32-bit word.
   function automatic logic [31:0] merge(input logic [31:0] old_v,
                                         input logic [31:0] new_v,
                                         input logic [3:0]  be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
      return r;
   endfunction

   logic [63:0]           mtime, mtimecmp;
   logic                  en, irq_en, pending;
   logic [PRESCALE_W-1:0] presc_reload, presc_cnt;

   logic        hit, rd, wr, unmapped, tick, w1c;
   logic [2:0]  off;
   logic [31:0] rd_val, ctrl_val, ctrl_new;
   logic        lint_unused;

   assign hit      = mem_req && (mem_addr[31:5] == BASE_ADDR[31:5]);
   assign off      = mem_addr[4:2];
   assign unmapped = off[2] & off[1];
   assign rd       = hit & ~mem_we & ~unmapped;
   assign wr       = hit &  mem_we & ~unmapped;
   assign tick     = en && (presc_cnt == '0);
   assign w1c      = wr && (off == 3'd5) && mem_byteen[0] && mem_wdata[0];

   assign ctrl_val = {16'(presc_reload), 14'b0, irq_en, en};
   assign ctrl_new = merge(ctrl_val, mem_wdata, mem_byteen);

   // Byte-offset bits and CTRL reserved bits are deliberately ignored.
   assign lint_unused = ^{mem_addr[1:0], ctrl_new[15:2]};

`ifdef TIMER_SHADOW_EN
   logic [31:0] mtime_shadow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       mtime_shadow <= '0;
      else if (rd && off == 3'd0)    mtime_shadow <= mtime[63:32];
   end
`endif

   // Read mux over register values as they stand before the clock edge.
   always_comb begin
      rd_val = '0;
      case (off)
         3'd0: rd_val = mtime[31:0];
`ifdef TIMER_SHADOW_EN
         3'd1: rd_val = mtime_shadow;
`else
         3'd1: rd_val = mtime[63:32];
`endif
         3'd2: rd_val = mtimecmp[31:0];
         3'd3: rd_val = mtimecmp[63:32];
         3'd4: rd_val = ctrl_val;
         3'd5: rd_val = {31'b0, pending};
         default: rd_val = '0;
      endcase
   end

   // Registers, prescaler and mtime. A bus write to either mtime half
   // wins over the tick in the same cycle, so the tick is simply lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime        <= '0;
         mtimecmp     <= '1;
         en           <= 1'b0;
         irq_en       <= 1'b0;
         presc_reload <= '0;
         presc_cnt    <= '0;
      end else begin
         if (en) presc_cnt <= tick ? presc_reload : presc_cnt - 1'b1;

         if (wr && off == 3'd0)
            mtime[31:0]  <= merge(mtime[31:0], mem_wdata, mem_byteen);
         else if (wr && off == 3'd1)
            mtime[63:32] <= merge(mtime[63:32], mem_wdata, mem_byteen);
         else if (tick)
            mtime <= mtime + 64'd1;

         if (wr && off == 3'd2)
            mtimecmp[31:0]  <= merge(mtimecmp[31:0], mem_wdata, mem_byteen);
         if (wr && off == 3'd3)
            mtimecmp[63:32] <= merge(mtimecmp[63:32], mem_wdata, mem_byteen);

         if (wr && off == 3'd4) begin
            en           <= ctrl_new[0];
            irq_en       <= ctrl_new[1];
            presc_reload <= ctrl_new[16 +: PRESCALE_W];
         end
      end
   end

   // Pending: compare wins over a simultaneous write-1-to-clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending   <= 1'b0;
         timer_irq <= 1'b0;
      end else begin
         pending   <= (mtime >= mtimecmp) | (pending & ~w1c);
         timer_irq <= pending & irq_en;
      end
   end

   // Bus response, one cycle after the request; zero when not answering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_rdata  <= '0;
         mem_rvalid <= 1'b0;
         mem_err    <= 1'b0;
      end else begin
         mem_rvalid <= rd;
         mem_rdata  <= rd ? rd_val : '0;
         mem_err    <= hit & unmapped;
      end
   end

endmodule
